stim_sequencer: RTL and testbench

Pulse-train scheduler for the TMS mainboard IGBT stage. It latches a stimulation configuration: on-time, pulse period, pulses per burst, burst period, burst count and channel mask. It then sequences one IGBT firing per pulse, rotating through the enabled channels. Hardware enforces one-hot drive and a minimum dead time, so downstream IGBT drivers never see overlapping gate commands. It sits between the UART command decoder (config/start/abort) and the IGBT gate outputs.

---
 rtl/stim_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_stim_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stim_sequencer.sv
// rtl/stim_sequencer.sv - IGBT pulse-train scheduler with one-hot gate drive and enforced dead time
module stim_sequencer #(
  parameter int CLK_PER_US = 50,
  parameter int DEAD_US    = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [4:0]  cfg_ch_mask,
  input  logic [15:0] cfg_on_time,
  input  logic [15:0] cfg_pulse_period,
  input  logic [7:0]  cfg_pulses,
  input  logic [23:0] cfg_burst_period,
  input  logic [7:0]  cfg_bursts,
  output logic [4:0]  IGBT,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  localparam int               SUB_W      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [SUB_W-1:0] SUB_TOP    = SUB_W'(CLK_PER_US - 1);
  localparam logic [16:0]      DEAD_TICKS = 17'(DEAD_US);

  typedef enum logic [2:0] {IDLE, FIRE, DEAD, GAP, BURST_WAIT} state_t;

  state_t           state;
  logic [2:0]       ch;
  logic [7:0]       pulse_idx;
  logic [7:0]       burst_idx;
  logic [15:0]      pulse_timer;
  logic [23:0]      burst_timer;
  logic [SUB_W-1:0] sub;
  logic [4:0]       mask_r;
  logic [15:0]      on_r;
  logic [15:0]      period_r;
  logic [7:0]       pulses_r;
  logic [23:0]      bperiod_r;
  logic [7:0]       bursts_r;
  logic             fin;
  logic             rej;

  // Next enabled channel strictly after cur, wrapping; cur=4 yields the lowest set bit.
  function automatic logic [2:0] next_ch(input logic [4:0] mask, input logic [2:0] cur);
    logic [2:0] pick;
    logic [2:0] idx;
    pick = cur;
    for (int k = 5; k >= 1; k--) begin
      idx = 3'((int'(cur) + k) % 5);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

  logic [15:0] on_in;
  logic [7:0]  pulses_in;
  logic [23:0] train_len;
  logic        cfg_bad;
  logic        tick;
  logic        on_due;
  logic        dead_due;
  logic        pulse_due;
  logic        burst_due;
  logic        last_pulse;
  logic        last_burst;
  logic        new_burst;
  logic [2:0]  nxt;

  assign on_in     = (cfg_on_time == 16'd0) ? 16'd1 : cfg_on_time;
  assign pulses_in = (cfg_pulses == 8'd0) ? 8'd1 : cfg_pulses;
  assign train_len = 24'(cfg_pulse_period) * 24'(pulses_in);
  assign cfg_bad   = (cfg_ch_mask == 5'd0)
                  || ((17'(on_in) + DEAD_TICKS) >= 17'(cfg_pulse_period))
                  || ((cfg_bursts != 8'd1) && (train_len > cfg_burst_period));

  // State moves only on tick edges; outputs follow one edge later, so each
  // firing lasts exactly on_eff*CLK_PER_US cycles starting the edge after accept.
  assign tick       = (sub == SUB_TOP);
  assign on_due     = tick && ((17'(pulse_timer) + 17'd1) == 17'(on_r));
  assign dead_due   = tick && ((17'(pulse_timer) + 17'd1) == (17'(on_r) + DEAD_TICKS));
  assign pulse_due  = tick && ((17'(pulse_timer) + 17'd1) == 17'(period_r));
  assign burst_due  = tick && ((25'(burst_timer) + 25'd1) == 25'(bperiod_r));
  assign last_pulse = (9'(pulse_idx) + 9'd1) >= 9'(pulses_r);
  assign last_burst = (bursts_r != 8'd0) && ((9'(burst_idx) + 9'd1) == 9'(bursts_r));
  assign new_burst  = burst_due && ((state == BURST_WAIT) || ((state == GAP) && pulse_due && last_pulse));
  assign nxt        = next_ch(mask_r, ch);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state       <= IDLE;
      ch          <= 3'd0;
      pulse_idx   <= 8'd0;
      burst_idx   <= 8'd0;
      pulse_timer <= 16'd0;
      burst_timer <= 24'd0;
      sub         <= '0;
      mask_r      <= 5'd0;
      on_r        <= 16'd0;
      period_r    <= 16'd0;
      pulses_r    <= 8'd0;
      bperiod_r   <= 24'd0;
      bursts_r    <= 8'd0;
      fin         <= 1'b0;
      rej         <= 1'b0;
      IGBT        <= 5'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      fin     <= 1'b0;
      rej     <= 1'b0;
      IGBT    <= (state == FIRE) ? (5'b00001 << ch) : 5'd0;
      busy    <= (state != IDLE);
      done    <= fin;
      cfg_err <= rej;
      sub     <= tick ? '0 : sub + SUB_W'(1);
      if (state != IDLE && tick) begin
        pulse_timer <= pulse_timer + 16'd1;
        burst_timer <= burst_timer + 24'd1;
      end
      if (abort) begin
        state <= IDLE;
        IGBT  <= 5'd0;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else if (new_burst) begin
        burst_idx   <= burst_idx + 8'd1;
        pulse_idx   <= 8'd0;
        pulse_timer <= 16'd0;
        burst_timer <= 24'd0;
        ch          <= nxt;
        state       <= FIRE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                rej <= 1'b1;
              end else begin
                mask_r      <= cfg_ch_mask;
                on_r        <= on_in;
                period_r    <= cfg_pulse_period;
                pulses_r    <= pulses_in;
                bperiod_r   <= cfg_burst_period;
                bursts_r    <= cfg_bursts;
                ch          <= next_ch(cfg_ch_mask, 3'd4);
                pulse_idx   <= 8'd0;
                burst_idx   <= 8'd0;
                pulse_timer <= 16'd0;
                burst_timer <= 24'd0;
                sub         <= '0;
                state       <= FIRE;
              end
            end
          end
          FIRE: if (on_due) state <= DEAD;
          DEAD: begin
            if (dead_due) begin
              if (last_pulse && last_burst) begin
                state <= IDLE;
                fin   <= 1'b1;
              end else begin
                state <= GAP;
              end
            end
          end
          GAP: begin
            if (pulse_due) begin
              if (!last_pulse) begin
                pulse_idx   <= pulse_idx + 8'd1;
                pulse_timer <= 16'd0;
                ch          <= nxt;
                state       <= FIRE;
              end else begin
                state <= BURST_WAIT;
              end
            end
          end
          BURST_WAIT: state <= BURST_WAIT;
          default:    state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// tb/tb_stim_sequencer.sv - scoreboard bench for stim_sequencer (1 us = 5 clocks for short runs)
module tb_stim_sequencer;

  localparam int CPU  = 5;
  localparam int DEAD = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  cfg_ch_mask = 5'd0;
  logic [15:0] cfg_on_time = 16'd0;
  logic [15:0] cfg_pulse_period = 16'd0;
  logic [7:0]  cfg_pulses = 8'd0;
  logic [23:0] cfg_burst_period = 24'd0;
  logic [7:0]  cfg_bursts = 8'd0;
  logic [4:0]  IGBT;
  logic        busy;
  logic        done;
  logic        cfg_err;

  stim_sequencer #(.CLK_PER_US(CPU), .DEAD_US(DEAD)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .start            (start),
    .abort            (abort),
    .cfg_ch_mask      (cfg_ch_mask),
    .cfg_on_time      (cfg_on_time),
    .cfg_pulse_period (cfg_pulse_period),
    .cfg_pulses       (cfg_pulses),
    .cfg_burst_period (cfg_burst_period),
    .cfg_bursts       (cfg_bursts),
    .IGBT             (IGBT),
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err)
  );

  always #5 sys_clk = ~sys_clk;

  longint cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // kind: 0 = gate rise, 1 = done pulse, 2 = cfg_err pulse
  typedef struct {int kind; int ch; longint t; longint w;} ev_t;
  ev_t exp_q[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         onehot_viol = 0;
  logic [4:0] prev_igbt = 5'd0;
  longint     rise_t = 0;
  longint     rise_w = 0;
  bit         aborting = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int nxt(input logic [4:0] m, input int c);
    for (int k = 1; k <= 5; k++) if (m[(c + k) % 5]) return (c + k) % 5;
    return c;
  endfunction

  function automatic int ch_of(input logic [4:0] v);
    for (int k = 0; k < 5; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic take(input int kind, input int ch);
    ev_t e;
    check("event_expected", longint'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_time", cyc, e.t);
      if (kind == 0) begin
        check("rise_channel", ch, e.ch);
        rise_w = e.w;
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if ((IGBT & (IGBT - 5'd1)) != 5'd0) onehot_viol++;
    if (IGBT != 5'd0 && prev_igbt != 5'd0 && IGBT != prev_igbt) onehot_viol++;
    if (IGBT != 5'd0 && prev_igbt == 5'd0) begin
      rise_t = cyc;
      take(0, ch_of(IGBT));
    end
    if (IGBT == 5'd0 && prev_igbt != 5'd0 && !aborting) check("on_width", cyc - rise_t, rise_w);
    if (done) begin
      take(1, 0);
      check("busy_low_at_done", longint'(busy), 0);
    end
    if (cfg_err) take(2, 0);
    prev_igbt = IGBT;
  end

  task automatic do_start(input logic [4:0] m, input int on, input int pp, input int np,
                          input int bp, input int nb, input bit with_abort, output longint n);
    @(negedge sys_clk);
    cfg_ch_mask      = m;
    cfg_on_time      = 16'(on);
    cfg_pulse_period = 16'(pp);
    cfg_pulses       = 8'(np);
    cfg_burst_period = 24'(bp);
    cfg_bursts       = 8'(nb);
    start            = 1'b1;
    abort            = with_abort;
    n                = cyc + 1;
    @(negedge sys_clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic push_train(input logic [4:0] m, input int on, input int pp, input int np,
                            input int bp, input int nb, input longint n, input bit with_done);
    int     c;
    int     on_e;
    longint t;
    c    = nxt(m, 4);
    on_e = (on == 0) ? 1 : on;
    t    = 0;
    for (int b = 0; b < nb; b++) begin
      for (int p = 0; p < ((np == 0) ? 1 : np); p++) begin
        t = n + 1 + longint'(CPU) * (longint'(b) * bp + longint'(p) * pp);
        exp_q.push_back('{kind: 0, ch: c, t: t, w: longint'(CPU * on_e)});
        c = nxt(m, c);
      end
    end
    if (with_done) exp_q.push_back('{kind: 1, ch: 0, t: t + CPU * (on_e + DEAD), w: 0});
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge sys_clk);
    @(negedge sys_clk);
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_igbt"}, longint'(IGBT), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
    check({tag, "_cfg_err"}, longint'(cfg_err), 0);
  endtask

  initial begin
    longint n;
    int     order[4];
    logic [4:0] rj_mask[4];
    int     rj_on[4], rj_pp[4], rj_np[4], rj_bp[4], rj_nb[4];

    repeat (3) @(negedge sys_clk);
    check_outputs_idle("reset");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Basic train: burst period equals train length (boundary accept)
    do_start(5'b00001, 100, 1000, 1, 1000, 3, 1'b0, n);
    push_train(5'b00001, 100, 1000, 1, 1000, 3, n, 1'b1);
    drain("basic_drain", 16000);

    // Rotation with explicit channel order; burst period ignored for a single burst
    do_start(5'b10110, 10, 50, 4, 0, 1, 1'b0, n);
    order = '{1, 2, 4, 1};
    for (int p = 0; p < 4; p++)
      exp_q.push_back('{kind: 0, ch: order[p], t: n + 1 + CPU * 50 * p, w: CPU * 10});
    exp_q.push_back('{kind: 1, ch: 0, t: n + 1 + CPU * 150 + CPU * 12, w: 0});
    drain("rotation_drain", 1500);

    // Continuous mode: three bursts observed, then abort while firing
    do_start(5'b00011, 5, 100, 2, 1000, 0, 1'b0, n);
    push_train(5'b00011, 5, 100, 2, 1000, 3, n, 1'b0);
    drain("continuous_drain", 12000);
    aborting = 1'b1;
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    @(negedge sys_clk);
    check("cont_abort_igbt", longint'(IGBT), 0);
    check("cont_abort_busy", longint'(busy), 0);
    repeat (6000) @(negedge sys_clk);
    check("cont_abort_quiet", exp_q.size(), 0);
    aborting = 1'b0;

    // Rejected starts
    rj_mask = '{5'b00000, 5'b00001, 5'b00001, 5'b00001};
    rj_on   = '{10, 99, 98, 10};
    rj_pp   = '{100, 100, 100, 200};
    rj_np   = '{1, 1, 1, 10};
    rj_bp   = '{100, 100, 100, 1999};
    rj_nb   = '{1, 1, 1, 2};
    for (int r = 0; r < 4; r++) begin
      do_start(rj_mask[r], rj_on[r], rj_pp[r], rj_np[r], rj_bp[r], rj_nb[r], 1'b0, n);
      exp_q.push_back('{kind: 2, ch: 0, t: n + 1, w: 0});
      drain("reject_drain", 5);
      check("reject_busy", longint'(busy), 0);
    end

    // Abort 1000 cycles into a firing
    do_start(5'b00100, 400, 1000, 1, 0, 1, 1'b0, n);
    exp_q.push_back('{kind: 0, ch: 2, t: n + 1, w: CPU * 400});
    aborting = 1'b1;
    while (cyc < n + 1000) @(negedge sys_clk);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    @(negedge sys_clk);
    check("fire_abort_igbt", longint'(IGBT), 0);
    check("fire_abort_busy", longint'(busy), 0);
    repeat (20) @(negedge sys_clk);
    check("fire_abort_quiet", exp_q.size(), 0);
    aborting = 1'b0;

    // Start and abort in the same cycle: abort wins
    do_start(5'b00001, 10, 100, 1, 100, 1, 1'b1, n);
    check("same_cycle_busy", longint'(busy), 0);
    repeat (20) @(negedge sys_clk);
    check("same_cycle_igbt", longint'(IGBT), 0);

    // Reset during GAP, then a normal run
    do_start(5'b00001, 10, 100, 2, 0, 1, 1'b0, n);
    exp_q.push_back('{kind: 0, ch: 0, t: n + 1, w: CPU * 10});
    while (cyc < n + 201) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_outputs_idle("gap_reset");
    sys_rst_n = 1'b1;
    repeat (600) @(negedge sys_clk);
    check("gap_reset_quiet", exp_q.size(), 0);
    do_start(5'b01000, 3, 10, 2, 0, 1, 1'b0, n);
    push_train(5'b01000, 3, 10, 2, 0, 1, n, 1'b1);
    drain("after_reset_drain", 300);

    // Config hold and start-while-busy
    do_start(5'b00001, 20, 100, 3, 0, 1, 1'b0, n);
    push_train(5'b00001, 20, 100, 3, 0, 1, n, 1'b1);
    @(negedge sys_clk);
    cfg_on_time = 16'd50;
    cfg_ch_mask = 5'b00000;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    drain("hold_drain", 2000);

    check("onehot_violations", onehot_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
